sysbus_mem_responder: RTL and testbench

//  Memory-side responder for the Sysbus request/response protocol; the counterpart of the

---
 rtl/sysbus_mem_responder.sv | 132 +++++++++++++
 tb/tb_sysbus_mem_responder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sysbus_mem_responder.sv
// Memory-side Sysbus responder: acks one request at a time, then streams a read burst
// after a fixed latency or absorbs a write burst and returns a single completion beat.
module sysbus_mem_responder #(
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 13,
  parameter int MEM_WORDS  = 4096,
  parameter int BEATS      = 8,
  parameter int LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reqcyc,
  input  logic [DATA_WIDTH-1:0] req,
  input  logic [TAG_WIDTH-1:0]  reqtag,
  output logic                  reqack,
  output logic                  respcyc,
  output logic [DATA_WIDTH-1:0] resp,
  output logic [TAG_WIDTH-1:0]  resptag,
  input  logic                  respack
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int BW = $clog2(BEATS) + 1;
  localparam int LW = $clog2(LATENCY + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WDATA, S_DELAY, S_RESP, S_WDONE
  } state_e;

  state_e                  state_q;
  logic [AW-1:0]           addr_q;
  logic [TAG_WIDTH-1:0]    tag_q;
  logic [BW-1:0]           beat_q;
  logic [LW-1:0]           dly_q;
  logic                    reqack_q;
  logic                    respcyc_q;
  logic [DATA_WIDTH-1:0]   resp_q;
  logic [TAG_WIDTH-1:0]    resptag_q;

  logic [DATA_WIDTH-1:0]   mem [MEM_WORDS];

  logic [BW-1:0]           beat_d;
  logic [AW-1:0]           cur_addr;
  logic [AW-1:0]           nxt_addr;
  logic                    last_beat;
  logic                    mem_we;

  // Addresses are AW bits wide, so the adds wrap modulo MEM_WORDS with no line wrap.
  assign beat_d    = beat_q + BW'(1);
  assign cur_addr  = addr_q + AW'(beat_q);
  assign nxt_addr  = addr_q + AW'(beat_d);
  assign last_beat = (beat_q == BW'(BEATS - 1));
  // The reqack cycle still carries the address phase, so write data starts one cycle later.
  assign mem_we    = (state_q == S_WDATA) && !reqack_q && reqcyc;

  // NOTE: the array has no reset; clearing thousands of words is neither needed nor wanted.
  always_ff @(posedge clk) begin
    if (mem_we) mem[cur_addr] <= req;
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      reqack_q  <= 1'b0;
      respcyc_q <= 1'b0;
      resp_q    <= '0;
      resptag_q <= '0;
      beat_q    <= '0;
      dly_q     <= '0;
    end else begin
      reqack_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (reqcyc) begin
            addr_q   <= req[3 +: AW];
            tag_q    <= reqtag;
            reqack_q <= 1'b1;
            beat_q   <= '0;
            dly_q    <= '0;
            state_q  <= reqtag[TAG_WIDTH-1] ? S_DELAY : S_WDATA;
          end
        end
        S_WDATA: begin
          if (mem_we) begin
            beat_q <= beat_d;
            if (last_beat) begin
              state_q   <= S_WDONE;
              respcyc_q <= 1'b1;
              resp_q    <= '0;
              resptag_q <= tag_q;
            end
          end
        end
        S_DELAY: begin
          if (dly_q == LW'(LATENCY)) begin
            state_q   <= S_RESP;
            respcyc_q <= 1'b1;
            resp_q    <= mem[addr_q];
            resptag_q <= tag_q;
          end else begin
            dly_q <= dly_q + LW'(1);
          end
        end
        S_RESP: begin
          if (respack) begin
            if (last_beat) begin
              respcyc_q <= 1'b0;
              state_q   <= S_IDLE;
            end else begin
              beat_q <= beat_d;
              resp_q <= mem[nxt_addr];
            end
          end
        end
        S_WDONE: begin
          if (respack) begin
            respcyc_q <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign reqack  = reqack_q;
  assign respcyc = respcyc_q;
  assign resp    = resp_q;
  assign resptag = resptag_q;

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Directed bench for sysbus_mem_responder: reset, write/read bursts, respack stalls,
// address wrap, mid-burst reset and write-data gaps, checked by immediate assertions.
module tb_sysbus_mem_responder;

  localparam int MW  = 4096;
  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        reqcyc;
  logic [63:0] req;
  logic [12:0] reqtag;
  logic        reqack;
  logic        respcyc;
  logic [63:0] resp;
  logic [12:0] resptag;
  logic        respack;

  int n_checks = 0;
  int n_fail   = 0;

  sysbus_mem_responder #(
    .DATA_WIDTH(64), .TAG_WIDTH(13), .MEM_WORDS(MW), .BEATS(8), .LATENCY(LAT)
  ) dut (
    .clk(clk), .reset(reset), .reqcyc(reqcyc), .req(req), .reqtag(reqtag),
    .reqack(reqack), .respcyc(respcyc), .resp(resp), .resptag(resptag),
    .respack(respack)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns positioned in the reqack cycle with the request withdrawn.
  task automatic do_req(input string name, input logic [12:0] tag, input logic [63:0] addr);
    bit got = 0;
    reqcyc = 1'b1;
    req    = addr;
    reqtag = tag;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      if (reqack === 1'b1) got = 1;
    end
    check({name, "_reqack"}, 64'(got), 64'd1);
    reqcyc = 1'b0;
    req    = '0;
  endtask

  task automatic write_burst(input string name, input logic [12:0] tag, input logic [63:0] addr,
                             input logic [63:0] base, input int gap_after);
    do_req(name, tag, addr);
    tick();
    for (int b = 0; b < 8; b++) begin
      reqcyc = 1'b1;
      req    = base + 64'(b);
      tick();
      if (b == gap_after) begin
        reqcyc = 1'b0;
        tick();
        check({name, "_gap_nocompl"}, 64'(respcyc), 64'd0);
        tick();
      end
    end
    reqcyc = 1'b0;
    req    = '0;
    check({name, "_done_cyc"}, 64'(respcyc), 64'd1);
    check({name, "_done_data"}, resp, 64'd0);
    check({name, "_done_tag"}, 64'(resptag), 64'(tag));
    respack = 1'b1;
    tick();
    respack = 1'b0;
    check({name, "_done_once"}, 64'(respcyc), 64'd0);
  endtask

  task automatic read_burst(input string name, input logic [12:0] tag, input logic [63:0] addr,
                            input logic [63:0] base, input logic [7:0] stall_mask,
                            input int stall_len, input int exp_cycles);
    int n_cyc = 0;
    do_req(name, tag, addr);
    for (int i = 0; i < LAT; i++) begin
      tick();
      check({name, "_latency_idle"}, 64'(respcyc), 64'd0);
    end
    tick();
    for (int b = 0; b < 8; b++) begin
      if (stall_mask[b]) begin
        respack = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          check({name, "_stall_data"}, resp, base + 64'(b));
          n_cyc += int'(respcyc);
          tick();
        end
      end
      respack = 1'b1;
      check({name, "_beat_cyc"}, 64'(respcyc), 64'd1);
      check({name, "_beat_data"}, resp, base + 64'(b));
      check({name, "_beat_tag"}, 64'(resptag), 64'(tag));
      n_cyc += int'(respcyc);
      tick();
    end
    respack = 1'b0;
    check({name, "_end_idle"}, 64'(respcyc), 64'd0);
    check({name, "_resp_cycles"}, 64'(n_cyc), 64'(exp_cycles));
  endtask

  initial begin
    int n_ack;
    int n_resp;
    reset   = 1'b0;
    reqcyc  = 1'b0;
    req     = '0;
    reqtag  = '0;
    respack = 1'b0;

    // 1: request held through reset is ignored, then acked exactly once.
    reqcyc = 1'b1;
    req    = 64'h0;
    reqtag = 13'h1001;
    tick();
    tick();
    check("t1_rst_reqack", 64'(reqack), 64'd0);
    check("t1_rst_respcyc", 64'(respcyc), 64'd0);
    check("t1_rst_resp", resp, 64'd0);
    check("t1_rst_resptag", 64'(resptag), 64'd0);
    reset = 1'b1;
    tick();
    check("t1_reqack_first", 64'(reqack), 64'd1);
    n_ack = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_ack += int'(reqack);
    end
    check("t1_reqack_once", 64'(n_ack), 64'd0);
    reqcyc  = 1'b0;
    respack = 1'b1;
    n_resp  = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      n_resp += int'(respcyc);
    end
    respack = 1'b0;
    check("t1_drain_beats", 64'(n_resp), 64'd8);
    check("t1_drain_idle", 64'(respcyc), 64'd0);

    // 2: write then read back at 0x1000.
    write_burst("t2_wr", 13'h0011, 64'h1000, 64'hA0, -1);
    read_burst("t2_rd", 13'h1022, 64'h1000, 64'hA0, 8'h00, 0, 8);

    // 3: respack low for three cycles on beats 2 and 5.
    read_burst("t3_rd", 13'h1033, 64'h1000, 64'hA0, 8'h24, 3, 14);

    // 4: burst crossing the top of the array, byte-offset bits ignored on read.
    write_burst("t4_wr", 13'h0044, 64'((MW - 3) * 8), 64'hC0, -1);
    read_burst("t4_rd", 13'h1055, 64'((MW - 3) * 8 + 5), 64'hC0, 8'h00, 0, 8);

    // 5: reset during beat 4 abandons the burst; array contents survive.
    do_req("t5_rd", 13'h1066, 64'h1000);
    for (int i = 0; i < LAT + 1; i++) tick();
    respack = 1'b1;
    for (int b = 0; b < 4; b++) begin
      check("t5_pre_data", resp, 64'hA0 + 64'(b));
      tick();
    end
    check("t5_beat4_data", resp, 64'hA4);
    reset   = 1'b0;
    respack = 1'b0;
    tick();
    check("t5_rst_respcyc", 64'(respcyc), 64'd0);
    check("t5_rst_resp", resp, 64'd0);
    check("t5_rst_resptag", 64'(resptag), 64'd0);
    reset = 1'b1;
    n_resp = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_resp += int'(respcyc);
    end
    check("t5_no_more_beats", 64'(n_resp), 64'd0);
    read_burst("t5_again", 13'h1077, 64'h1000, 64'hA0, 8'h00, 0, 8);

    // 6: write with reqcyc gaps between beats 3 and 4.
    write_burst("t6_wr", 13'h0088, 64'h2000, 64'hD0, 3);
    read_burst("t6_rd", 13'h1099, 64'h2000, 64'hD0, 8'h00, 0, 8);
    read_burst("t6_wrap_intact", 13'h10AA, 64'((MW - 3) * 8), 64'hC0, 8'h00, 0, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
